// File: rtl/window_scan_ctrl.sv
// Frame-level sequencer for the sliding-window datapath.
// Accepts a raster pixel stream, emits one registered advance strobe per
// accepted pixel with its column/row, qualifies window validity, and flags
// frame completion and mid-frame start-of-frame errors.
module window_scan_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int WIN_SIZE     = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [DATA_WIDTH-1:0]           s_data,
    input  logic                            s_sof,
    input  logic                            m_ready,
    output logic                            pix_en,
    output logic [DATA_WIDTH-1:0]           pix_data,
    output logic [$clog2(IMAGE_WIDTH)-1:0]  pix_col,
    output logic [$clog2(IMAGE_HEIGHT)-1:0] pix_row,
    output logic                            win_valid,
    output logic                            frame_done,
    output logic                            err_sof
);

    localparam int CW = $clog2(IMAGE_WIDTH);
    localparam int RW = $clog2(IMAGE_HEIGHT);

    localparam logic [CW-1:0] COL_LAST    = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST    = RW'(IMAGE_HEIGHT - 1);
    localparam logic [CW-1:0] WIN_COL_MIN = CW'(WIN_SIZE - 1);
    localparam logic [RW-1:0] WIN_ROW_MIN = RW'(WIN_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;     // position of the next pixel expected
    logic [RW-1:0]   row_q, row_d;

    logic            accept;           // handshake completed this cycle
    logic            take;             // accepted pixel enters the frame
    logic            mid_sof;          // sof arrived while a frame was running
    logic            last;             // accepted pixel closes the frame
    logic [CW-1:0]   cur_col;          // position assigned to the accepted pixel
    logic [RW-1:0]   cur_row;

    logic                  pix_en_q;
    logic [DATA_WIDTH-1:0] pix_data_q;
    logic [CW-1:0]         pix_col_q;
    logic [RW-1:0]         pix_row_q;
    logic                  win_valid_q;
    logic                  frame_done_q;
    logic                  err_sof_q;

    // State register and position counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    // Next-state: frame entry on sof, exit on last pixel, DONE is a single cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take) state_d = last ? DONE : ACTIVE;
            ACTIVE:  if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/handshake decode; a sof always re-anchors the pixel at (0,0)
    always_comb begin
        s_ready = 1'b0;
        case (state_q)
            IDLE:    s_ready = 1'b1;
            ACTIVE:  s_ready = m_ready;
            default: s_ready = 1'b0;
        endcase
        s_ready = s_ready && rst_n;
        accept  = s_valid && s_ready;
        take    = accept && ((state_q == ACTIVE) || s_sof);
        mid_sof = accept && s_sof && (state_q == ACTIVE) &&
                  ((col_q != '0) || (row_q != '0));
        cur_col = s_sof ? '0 : col_q;
        cur_row = s_sof ? '0 : row_q;
        last    = take && (cur_col == COL_LAST) && (cur_row == ROW_LAST);
    end

    // Counter advance: raster order, cleared when the frame closes
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (take) begin
            if (last) begin
                col_d = '0;
                row_d = '0;
            end else if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
        end else if (state_q == DONE) begin
            col_d = '0;
            row_d = '0;
        end
    end

    // Registered pixel stream; win_valid trails pix_en by one edge to line up
    // with the window buffer output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_en_q     <= 1'b0;
            pix_data_q   <= '0;
            pix_col_q    <= '0;
            pix_row_q    <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            err_sof_q    <= 1'b0;
        end else begin
            pix_en_q <= take;
            if (take) begin
                pix_data_q <= s_data;
                pix_col_q  <= cur_col;
                pix_row_q  <= cur_row;
            end
            win_valid_q  <= pix_en_q && (pix_col_q >= WIN_COL_MIN) &&
                            (pix_row_q >= WIN_ROW_MIN);
            frame_done_q <= (state_q == DONE);
            err_sof_q    <= mid_sof;
        end
    end

    assign pix_en     = pix_en_q;
    assign pix_data   = pix_data_q;
    assign pix_col    = pix_col_q;
    assign pix_row    = pix_row_q;
    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;
    assign err_sof    = err_sof_q;

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Scoreboard bench for window_scan_ctrl on an 8x4 image with a 3x3 window.
module tb_window_scan_ctrl;

    localparam int W   = 8;
    localparam int H   = 4;
    localparam int WIN = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = 8'h00;
    logic       s_sof = 1'b0;
    logic       m_ready = 1'b1;
    logic       pix_en;
    logic [7:0] pix_data;
    logic [2:0] pix_col;
    logic [1:0] pix_row;
    logic       win_valid;
    logic       frame_done;
    logic       err_sof;

    window_scan_ctrl #(
        .DATA_WIDTH(8), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .WIN_SIZE(WIN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_sof(s_sof), .m_ready(m_ready), .pix_en(pix_en),
        .pix_data(pix_data), .pix_col(pix_col), .pix_row(pix_row),
        .win_valid(win_valid), .frame_done(frame_done), .err_sof(err_sof)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] c;
        logic [1:0] r;
        logic [7:0] d;
        logic       err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;
    int   n_pix = 0, n_win = 0, n_fd = 0, n_err = 0;

    // reference raster position of the next pixel
    int   mc = 0, mr = 0;
    bit   mact = 0;

    function automatic void model_accept(input logic [7:0] d, input logic sof);
        exp_t e;
        if (sof) begin
            e.err = mact && !(mc == 0 && mr == 0);
            mc = 0; mr = 0; mact = 1;
        end else begin
            e.err = 1'b0;
        end
        if (!mact) return;
        e.c = 3'(mc); e.r = 2'(mr); e.d = d;
        q.push_back(e);
        if (mc == W - 1) begin
            mc = 0;
            if (mr == H - 1) begin mr = 0; mact = 0; end
            else mr++;
        end else begin
            mc++;
        end
    endfunction

    // output monitor: pops the scoreboard on pix_en, checks the derived strobes
    bit prev_win = 0;
    bit fd_pend = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_win = 0;
            fd_pend  = 0;
        end else begin
            checks++;
            if (win_valid !== prev_win)
                $display("FAIL win_valid got=%b exp=%b t=%0t", win_valid, prev_win, $time);
            else passes++;
            checks++;
            if (frame_done !== fd_pend)
                $display("FAIL frame_done got=%b exp=%b t=%0t", frame_done, fd_pend, $time);
            else passes++;
            if (pix_en) begin
                checks++;
                if (q.size() == 0) begin
                    $display("FAIL unexpected_pix_en col=%0d row=%0d t=%0t", pix_col, pix_row, $time);
                    prev_win = 0;
                    fd_pend  = 0;
                end else begin
                    e = q.pop_front();
                    if (pix_col !== e.c || pix_row !== e.r || pix_data !== e.d || err_sof !== e.err)
                        $display("FAIL pixel got=(%0d,%0d,%h,err%b) exp=(%0d,%0d,%h,err%b) t=%0t",
                                 pix_col, pix_row, pix_data, err_sof, e.c, e.r, e.d, e.err, $time);
                    else passes++;
                    prev_win = (e.c >= 3'(WIN - 1)) && (e.r >= 2'(WIN - 1));
                    fd_pend  = (e.c == 3'(W - 1)) && (e.r == 2'(H - 1));
                end
                n_pix++;
            end else begin
                checks++;
                if (err_sof !== 1'b0)
                    $display("FAIL err_sof_idle got=%b exp=0 t=%0t", err_sof, $time);
                else passes++;
                prev_win = 0;
                fd_pend  = 0;
            end
            if (win_valid)  n_win++;
            if (frame_done) n_fd++;
            if (err_sof)    n_err++;
        end
    end

    // present one pixel and hold it until accepted; returns at posedge+1
    task automatic drive(input logic [7:0] d, input logic sof, input bit gaps);
        bit done = 0;
        if (gaps && $urandom_range(1) == 0) begin
            @(posedge clk); #1;
        end
        s_valid = 1'b1; s_data = d; s_sof = sof;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (s_ready) begin
                model_accept(d, sof);
                done = 1;
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0; s_sof = 1'b0;
        if (!done) begin
            checks++;
            $display("FAIL drive_timeout s_ready stuck at %b exp=1", s_ready);
        end
    endtask

    task automatic send_pixels(input int first, input int last_idx, input bit gaps);
        for (int i = first; i <= last_idx; i++)
            drive(8'($urandom_range(255)), i == 0, gaps);
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string name, input int dp, input int ep,
                                input int dw, input int ew, input int df, input int ef);
        checks++;
        if (dp !== ep || dw !== ew || df !== ef)
            $display("FAIL %s counts got pix=%0d win=%0d fd=%0d exp pix=%0d win=%0d fd=%0d",
                     name, dp, dw, df, ep, ew, ef);
        else passes++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({pix_en, pix_data, pix_col, pix_row, win_valid, frame_done, err_sof, s_ready} !== '0)
            $display("FAIL reset_outputs got en=%b d=%h c=%0d r=%0d wv=%b fd=%b err=%b rdy=%b exp all 0",
                     pix_en, pix_data, pix_col, pix_row, win_valid, frame_done, err_sof, s_ready);
        else passes++;
        s_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (s_ready !== 1'b1) $display("FAIL reset_idle_ready got=%b exp=1", s_ready);
        else passes++;
    endtask

    task automatic test_continuous();
        int bp = n_pix, bw = n_win, bf = n_fd;
        send_pixels(0, 31, 0);
        checks++;
        if (s_ready !== 1'b0) $display("FAIL done_ready got=%b exp=0", s_ready);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if (s_ready !== 1'b1 || frame_done !== 1'b1)
            $display("FAIL after_done got rdy=%b fd=%b exp rdy=1 fd=1", s_ready, frame_done);
        else passes++;
        checks++;
        if (pix_col !== 3'd7 || pix_row !== 2'd3)
            $display("FAIL last_coord got=(%0d,%0d) exp=(7,3)", pix_col, pix_row);
        else passes++;
        settle();
        check_counts("continuous", n_pix - bp, 32, n_win - bw, 12, n_fd - bf, 1);
    endtask

    task automatic test_idle_drop();
        int bp = n_pix;
        for (int i = 0; i < 5; i++) drive(8'(i + 1), 1'b0, 0);
        settle();
        checks++;
        if (n_pix !== bp || s_ready !== 1'b1)
            $display("FAIL idle_drop got pix=%0d rdy=%b exp pix=0 rdy=1", n_pix - bp, s_ready);
        else passes++;
        send_pixels(0, 31, 0);
        settle();
    endtask

    task automatic test_stall();
        int bp = n_pix, bw = n_win, bf = n_fd;
        send_pixels(0, 12, 0);            // last pixel sent is (4,1)
        m_ready = 1'b0; s_valid = 1'b1; s_data = 8'hAA;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (s_ready !== 1'b0) $display("FAIL stall_ready cyc=%0d got=%b exp=0", i, s_ready);
            else passes++;
        end
        @(posedge clk); #1;
        checks++;
        if (n_pix - bp !== 13) $display("FAIL stall_pix got=%0d exp=13", n_pix - bp);
        else passes++;
        m_ready = 1'b1; s_valid = 1'b0;
        send_pixels(13, 31, 0);           // first resumes at (5,1)
        settle();
        check_counts("stall", n_pix - bp, 32, n_win - bw, 12, n_fd - bf, 1);
    endtask

    task automatic test_sof_error();
        int bp = n_pix, bf = n_fd, be = n_err;
        send_pixels(0, 9, 0);
        drive(8'h5A, 1'b1, 0);            // index 10 restarts the frame
        for (int i = 0; i < 30; i++) drive(8'($urandom_range(255)), 1'b0, 0);
        settle();
        checks++;
        if (n_fd - bf !== 0 || n_err - be !== 1)
            $display("FAIL sof_err_mid got fd=%0d err=%0d exp fd=0 err=1", n_fd - bf, n_err - be);
        else passes++;
        drive(8'h77, 1'b0, 0);
        settle();
        check_counts("sof_error", n_pix - bp, 42, 0, 0, n_fd - bf, 1);
    endtask

    task automatic test_reset_midframe();
        int bp, bw, bf;
        send_pixels(0, 19, 0);            // pixel 19 is (3,2)
        rst_n = 1'b0; s_valid = 1'b1;
        q.delete(); mact = 0; mc = 0; mr = 0;
        #1;
        checks++;
        if ({pix_en, pix_data, pix_col, pix_row, win_valid, frame_done, err_sof, s_ready} !== '0)
            $display("FAIL midreset_outputs got en=%b d=%h c=%0d r=%0d wv=%b fd=%b err=%b rdy=%b exp all 0",
                     pix_en, pix_data, pix_col, pix_row, win_valid, frame_done, err_sof, s_ready);
        else passes++;
        repeat (2) @(posedge clk);
        #1;
        s_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (s_ready !== 1'b1) $display("FAIL midreset_idle got rdy=%b exp=1", s_ready);
        else passes++;
        bp = n_pix; bw = n_win; bf = n_fd;
        send_pixels(0, 31, 0);
        settle();
        check_counts("after_reset", n_pix - bp, 32, n_win - bw, 12, n_fd - bf, 1);
    endtask

    task automatic test_random_gaps();
        int bp = n_pix, bw = n_win, bf = n_fd;
        send_pixels(0, 31, 1);
        settle();
        check_counts("random_gaps", n_pix - bp, 32, n_win - bw, 12, n_fd - bf, 1);
    endtask

    task automatic test_back_to_back();
        int bp = n_pix, bw = n_win, bf = n_fd;
        send_pixels(0, 31, 0);
        send_pixels(0, 31, 0);            // sof lands during DONE and waits a cycle
        settle();
        check_counts("back_to_back", n_pix - bp, 64, n_win - bw, 24, n_fd - bf, 2);
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_idle_drop();
        test_stall();
        test_sof_error();
        test_reset_midframe();
        test_random_gaps();
        test_back_to_back();
        settle();
        checks++;
        if (q.size() !== 0) $display("FAIL scoreboard_drain left=%0d exp=0", q.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
